seven_segment_scanner: RTL and testbench
========================================

// Module: seven_segment_scanner
// PURPOSE
// - Time-multiplexed 7-segment display driver. Reads the packed digit outputs of the chained
//   stopwatch counters and scans one digit at a time onto shared segment/anode pins.
// - Sits between the counter chain and the board display pins.
// - Latches digits once per frame, so a digit that rolls over mid-scan never tears the display.
// PARAMETERS
// - NUMBER_OF_DIGITS  default 4       digits scanned; legal range 2..8
// - REFRESH_DIVIDE    default 100000  clk cycles per digit slot; must be >= 2
// - DEAD_CYCLES       default 16      cycles at slot start with all anodes off (anti-ghosting);
//                                     must be < REFRESH_DIVIDE
// - ACTIVE_LOW        default 1       1 = anode/segment/dp pins active-low (common anode)
// PORTS
// - clk          in   1      clock
// - rst          in   1      asynchronous, active-high reset
// - enable       in   1      1 = scan, 0 = display dark
// - digits       in   4*NUMBER_OF_DIGITS  digit i at [4i+3:4i]; digit 0 is the least significant
// - dp_mask      in   NUMBER_OF_DIGITS    1 = light the decimal point of digit i
// - blank_lead   in   1      1 = blank leading zeros (digit 0 is never blanked)
// - anode        out  NUMBER_OF_DIGITS    one-hot digit select (polarity per ACTIVE_LOW)
// - segments     out  7      {g,f,e,d,c,b,a} (polarity per ACTIVE_LOW)
// - dp           out  1      decimal point (polarity per ACTIVE_LOW)
// - frame_start  out  1      one-cycle pulse when slot 0 begins (snapshot taken)
// BEHAVIOUR
// Reset (async, rst=1):
// - slot counter=0, digit index=0, snapshot=0.
// - anode, segments and dp all inactive: all 1s when ACTIVE_LOW=1, all 0s otherwise.
// - frame_start=0.
// Slot counter:
// - Counts 0..REFRESH_DIVIDE-1 while enable=1.
// - At the terminal count it wraps to 0 and the index advances. Index wraps
//   NUMBER_OF_DIGITS-1 -> 0.
// Snapshot:
// - On the cycle the index becomes 0 (wrap, or first cycle after enable rises), digits,
//   dp_mask and blank_lead are registered into the snapshot.
// - frame_start pulses high in that same cycle.
// - Input changes at any other time have no effect until the next frame.
// Blanking:
// - With blank_lead=1, snapshot digit i (i>0) is blanked when it and every more-significant
//   snapshot digit equal 0.
// - A blanked digit drives all segments inactive; its dp still follows dp_mask.
// Decode:
// - 0-9 -> standard glyphs; 10-15 -> A,b,C,d,E,F. Width fixed at 4 bits per digit.
// Output timing:
// - Outputs are registered: pins reflect the counter/index state of the previous cycle.
// - Slot counter values 0..DEAD_CYCLES-1: anode all inactive; segments/dp already show the
//   new digit.
// - Remaining slot cycles: anode[index] active, all other anodes inactive.
// Enable:
// - enable=0: synchronous clear of counter and index to 0; all outputs inactive the next
//   cycle; frame_start=0.
// - enable rising: the first active cycle starts frame 0 with slot counter 0.
// Reset mid-scan: all state and outputs go inactive immediately; scanning restarts at digit 0
// after release (when enable=1).
// Invariant: at most one anode is active at any time, including across the index change.
// TESTING (bench params: REFRESH_DIVIDE=4, DEAD_CYCLES=1, NUMBER_OF_DIGITS=4, ACTIVE_LOW=1)
// 1. Reset, enable=1, digits=16'h1234, blank_lead=0
//    -> anode sequence 1111,1110x3,1111,1101x3,... ; digit0 segments=7'b0011001 ("4");
//       frame_start every 16 cycles.
// 2. digits changed 16'h1234 -> 16'h5678 mid-frame (during digit 1)
//    -> digits 2,3 still show 2,1; "8765" appears only after the next frame_start.
// 3. digits=16'h0070, blank_lead=1
//    -> digit3 and digit2 segments=7'h7F (blank); digit1 shows "7"; digit0 shows "0".
// 4. digits=16'h0000, blank_lead=1, dp_mask=4'b0100
//    -> only digit0 shows "0"; digit2 blank but dp=0 (lit).
// 5. enable dropped for 3 cycles mid-slot, then raised
//    -> anode=1111 from the next edge; on rise, digit 0 slot restarts with a fresh frame_start.
// 6. rst asserted mid-slot (not aligned to clk)
//    -> anode/segments/dp=all 1s asynchronously; digit 0 scan resumes after release.
//    Checker on every cycle: $countones(~anode) <= 1.

Source files
------------

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed 7-segment driver: snapshots the digit bus once per frame and
// scans one digit per slot onto shared anode/segment/dp pins.
module seven_segment_scanner #(
    parameter int NUMBER_OF_DIGITS = 4,
    parameter int REFRESH_DIVIDE   = 100000,
    parameter int DEAD_CYCLES      = 16,
    parameter bit ACTIVE_LOW       = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [4*NUMBER_OF_DIGITS-1:0] digits,
    input  logic [NUMBER_OF_DIGITS-1:0]   dp_mask,
    input  logic                          blank_lead,
    output logic [NUMBER_OF_DIGITS-1:0]   anode,
    output logic [6:0]                    segments,
    output logic                          dp,
    output logic                          frame_start
);

    localparam int N     = NUMBER_OF_DIGITS;
    localparam int CNT_W = $clog2(REFRESH_DIVIDE);
    localparam int IDX_W = $clog2(NUMBER_OF_DIGITS);
    localparam logic [N-1:0] AN_OFF  = {N{ACTIVE_LOW}};
    localparam logic [6:0]   SEG_OFF = {7{ACTIVE_LOW}};

    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic              running;
    logic [N-1:0][3:0] snap_digits;
    logic [N-1:0]      snap_dp;
    logic              snap_blank;

    logic              slot_end, frame_end, new_frame;
    logic [N-1:0]      blank;
    logic [N-1:0]      anode_on;
    logic [6:0]        seg_on;
    logic              dp_on;
    logic              lead;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'h3F;
            4'h1: decode = 7'h06;
            4'h2: decode = 7'h5B;
            4'h3: decode = 7'h4F;
            4'h4: decode = 7'h66;
            4'h5: decode = 7'h6D;
            4'h6: decode = 7'h7D;
            4'h7: decode = 7'h07;
            4'h8: decode = 7'h7F;
            4'h9: decode = 7'h6F;
            4'hA: decode = 7'h77;
            4'hB: decode = 7'h7C;
            4'hC: decode = 7'h39;
            4'hD: decode = 7'h5E;
            4'hE: decode = 7'h79;
            default: decode = 7'h71;
        endcase
    endfunction

    assign slot_end  = (cnt == CNT_W'(REFRESH_DIVIDE - 1));
    assign frame_end = slot_end && (idx == IDX_W'(N - 1));
    // First cycle after enable rises also opens a frame
    assign new_frame = enable && (!running || frame_end);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            idx     <= '0;
            running <= 1'b0;
        end else if (!enable) begin
            cnt     <= '0;
            idx     <= '0;
            running <= 1'b0;
        end else if (!running) begin
            cnt     <= '0;
            idx     <= '0;
            running <= 1'b1;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= frame_end ? '0 : idx + IDX_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_blank  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= new_frame;
            if (new_frame) begin
                snap_digits <= digits;
                snap_dp     <= dp_mask;
                snap_blank  <= blank_lead;
            end
        end
    end

    // A digit blanks only while it and everything above it are zero
    always_comb begin
        blank = '0;
        lead  = snap_blank;
        for (int i = N - 1; i > 0; i--) begin
            lead     = lead && (snap_digits[i] == 4'h0);
            blank[i] = lead;
        end
    end

    always_comb begin
        anode_on = '0;
        seg_on   = '0;
        dp_on    = 1'b0;
        if (running) begin
            seg_on = blank[idx] ? 7'h00 : decode(snap_digits[idx]);
            dp_on  = snap_dp[idx];
            if (32'(cnt) >= DEAD_CYCLES)
                anode_on[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anode    <= AN_OFF;
            segments <= SEG_OFF;
            dp       <= ACTIVE_LOW;
        end else if (!enable) begin
            anode    <= AN_OFF;
            segments <= SEG_OFF;
            dp       <= ACTIVE_LOW;
        end else begin
            anode    <= anode_on ^ AN_OFF;
            segments <= seg_on ^ SEG_OFF;
            dp       <= dp_on ^ ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: per-digit scoreboard filled at each frame
// snapshot, plus cycle-exact anode/frame_start checks and a one-hot anode watch.
module tb_seven_segment_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic        blank_lead;
    logic [3:0]  anode;
    logic [6:0]  segments;
    logic        dp;
    logic        frame_start;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dpv;
    } exp_t;

    exp_t sb[$];
    logic [3:0] prev_anode = 4'hF;

    seven_segment_scanner #(
        .NUMBER_OF_DIGITS(4),
        .REFRESH_DIVIDE(4),
        .DEAD_CYCLES(1),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .digits(digits),
        .dp_mask(dp_mask), .blank_lead(blank_lead), .anode(anode),
        .segments(segments), .dp(dp), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[v];
    endfunction

    // Expected pin values (active-low) for the four slots of one frame
    task automatic push_frame(input logic [15:0] d, input logic [3:0] m, input logic bl);
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            logic blk;
            blk = bl && (i > 0);
            for (int j = i; j < 4; j++)
                if (d[4*j +: 4] != 4'h0) blk = 1'b0;
            e.an  = ~(4'b0001 << i);
            e.seg = blk ? 7'h7F : ~glyph(d[4*i +: 4]);
            e.dpv = ~m[i];
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if ($countones(~anode) > 1) begin
                bad++;
                $display("FAIL onehot: anode=%b, at most one low bit allowed", anode);
            end
        end
        if (anode != 4'hF && prev_anode == 4'hF && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if ({anode, segments, dp} !== {e.an, e.seg, e.dpv}) begin
                bad++;
                $display("FAIL slot: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         anode, segments, dp, e.an, e.seg, e.dpv);
            end
        end
        prev_anode = anode;
    end

    task automatic wait_frame();
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!frame_start && n < 40);
        total++;
        if (!frame_start) begin
            bad++;
            $display("FAIL frame_timeout: frame_start=0 after %0d cycles, want 1", n);
        end
    endtask

    task automatic wait_anode(input logic [3:0] want);
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (anode !== want && n < 40);
        total++;
        if (anode !== want) begin
            bad++;
            $display("FAIL anode_timeout: anode=%b want %b", anode, want);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 60) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d slots never shown, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; digits = 16'h1234; dp_mask = 4'b0000; blank_lead = 1'b0;
        #12;
        total++;
        if ({anode, segments, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset: an=%b seg=%b dp=%b fs=%b want 1111 1111111 1 0",
                     anode, segments, dp, frame_start);
        end
    endtask

    task automatic test_scan_sequence();
        logic [3:0] exp_an;
        logic       exp_fs;
        enable = 1'b1;
        @(negedge clk); #2 rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); #1;
            if (k < 2) exp_an = 4'hF;
            else if ((k - 2) % 4 == 0) exp_an = 4'hF;
            else exp_an = ~(4'b0001 << (((k - 2) / 4) % 4));
            exp_fs = (k == 1) || ((k - 1) % 16 == 0);
            total++;
            if (anode !== exp_an || frame_start !== exp_fs) begin
                bad++;
                $display("FAIL scan_seq k=%0d: an=%b fs=%b want an=%b fs=%b",
                         k, anode, frame_start, exp_an, exp_fs);
            end
            if (frame_start) push_frame(digits, dp_mask, blank_lead);
        end
        drain();
    endtask

    task automatic test_mid_frame_change();
        wait_frame();
        push_frame(16'h1234, 4'b0000, 1'b0);
        wait_anode(4'b1101);
        digits = 16'h5678;
        wait_frame();
        push_frame(16'h5678, 4'b0000, 1'b0);
        drain();
    endtask

    task automatic test_blank_lead();
        digits = 16'h0070; blank_lead = 1'b1; dp_mask = 4'b0000;
        wait_frame();
        push_frame(16'h0070, 4'b0000, 1'b1);
        drain();
        digits = 16'h0000; dp_mask = 4'b0100;
        wait_frame();
        push_frame(16'h0000, 4'b0100, 1'b1);
        drain();
        digits = 16'hA0C0; blank_lead = 1'b1; dp_mask = 4'b1001;
        wait_frame();
        push_frame(16'hA0C0, 4'b1001, 1'b1);
        drain();
    endtask

    task automatic test_enable();
        digits = 16'hBEEF; blank_lead = 1'b0; dp_mask = 4'b0010;
        wait_anode(4'b1011);
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++;
            if ({anode, segments, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL disabled k=%0d: an=%b seg=%b dp=%b fs=%b want 1111 1111111 1 0",
                         k, anode, segments, dp, frame_start);
            end
        end
        enable = 1'b1;
        @(posedge clk); #1;
        total++;
        if (frame_start !== 1'b1 || anode !== 4'hF) begin
            bad++;
            $display("FAIL enable_rise: fs=%b an=%b want fs=1 an=1111", frame_start, anode);
        end
        push_frame(16'hBEEF, 4'b0010, 1'b0);
        drain();
    endtask

    task automatic test_async_reset();
        digits = 16'h9081; dp_mask = 4'b1000;
        wait_anode(4'b1101);
        @(negedge clk); #2 rst = 1'b1;
        #1;
        total++;
        if ({anode, segments, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL async_rst: an=%b seg=%b dp=%b fs=%b want 1111 1111111 1 0",
                     anode, segments, dp, frame_start);
        end
        #13 rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (frame_start !== 1'b1) begin
            bad++;
            $display("FAIL rst_restart: fs=%b want 1", frame_start);
        end
        push_frame(16'h9081, 4'b1000, 1'b0);
        drain();
    endtask

    initial begin
        test_reset();
        test_scan_sequence();
        test_mid_frame_change();
        test_blank_lead();
        test_enable();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
